// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential PC generation, ITCM reads, instruction queue, branch redirect with flush.
// Latency: request at cycle N, ITCM data at N+1, inst_valid_o at N+2; a redirect's first request issues the next cycle.
// Backpressure: inst_ready_i low fills the queue; requests stop while queued plus in-flight words would exceed QDEPTH.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     QDEPTH   = 4,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         imem_req_o,
    output logic [XLEN-1:0]              imem_addr_o,
    input  logic [XLEN-1:0]              imem_rdata_i,
    input  logic                         redirect_i,
    input  logic [XLEN-1:0]              redirect_pc_i,
    output logic                         inst_valid_o,
    output logic [XLEN-1:0]              inst_o,
    output logic [XLEN-1:0]              inst_pc_o,
    input  logic                         inst_ready_i,
    output logic [$clog2(QDEPTH+1)-1:0]  q_count_o
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q;
    logic [CW-1:0]   count_q;
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic            rsp_v_q;
    logic [XLEN-1:0] rsp_pc_q;

    logic [XLEN-1:0] q_inst [QDEPTH];
    logic [XLEN-1:0] q_pc   [QDEPTH];

    logic            credit_ok;
    logic            push;
    logic            pop;
    logic [PW-1:0]   rd_ptr_nxt, wr_ptr_nxt;

    // Conservative credit: words already queued plus the one in flight must leave room; a same-cycle pop is ignored.
    assign credit_ok  = ({1'b0, count_q} + (CW+1)'(rsp_v_q)) < (CW+1)'(QDEPTH);
    assign push       = rsp_v_q & ~redirect_i;
    assign pop        = inst_valid_o & inst_ready_i;
    assign rd_ptr_nxt = (rd_ptr_q == PW'(QDEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    assign wr_ptr_nxt = (wr_ptr_q == PW'(QDEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);

    assign imem_addr_o  = fetch_pc_q;
    assign inst_valid_o = (count_q != '0);
    assign q_count_o    = count_q;
    // Head fields read as zero when empty so reset/flush drive clean outputs immediately.
    assign inst_o       = inst_valid_o ? q_inst[rd_ptr_q] : '0;
    assign inst_pc_o    = inst_valid_o ? q_pc[rd_ptr_q]   : '0;

    // Next-state and request decode: one idle WAIT cycle after reset, then RUN until reset.
    always_comb begin
        state_d    = state_q;
        imem_req_o = 1'b0;
        if (state_q == ST_WAIT) begin
            state_d = ST_RUN;
        end else begin
            imem_req_o = ~redirect_i & credit_ok;
        end
    end

    // Control state: PC, response tracking, queue pointers and occupancy; redirect flushes ahead of everything else.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_WAIT;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rsp_v_q    <= 1'b0;
            rsp_pc_q   <= '0;
        end else begin
            state_q  <= state_d;
            rsp_v_q  <= imem_req_o;
            rsp_pc_q <= fetch_pc_q;
            if (redirect_i) begin
                fetch_pc_q <= redirect_pc_i;
                count_q    <= '0;
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
            end else begin
                if (imem_req_o) begin
                    fetch_pc_q <= fetch_pc_q + XLEN'(PC_STEP);
                end
                if (push) begin
                    wr_ptr_q <= wr_ptr_nxt;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_nxt;
                end
                if (push && !pop) begin
                    count_q <= count_q + CW'(1);
                end else if (pop && !push) begin
                    count_q <= count_q - CW'(1);
                end
            end
        end
    end

    // Queue storage; contents need no reset because the head is masked by the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr_q] <= imem_rdata_i;
            q_pc[wr_ptr_q]   <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed latency/backpressure/redirect/wrap/reset steps, then randomized ready and redirects.
// A behavioural ITCM answers each request one cycle later; a monitor scoreboards every accepted instruction.
// Inputs change on the falling edge; outputs are sampled 2-3 time units later.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;
    logic [2:0]  q_count_o;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int req_seen = 0;
    int hs_cnt   = 0;
    logic [31:0] exp_q [$];

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0),
        .QDEPTH   (4),
        .PC_STEP  (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_ready_i  (inst_ready_i),
        .q_count_o     (q_count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] itcm(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // ITCM: one-cycle read latency; junk when no request so any bypass or stale capture shows up.
    always @(posedge clk) begin
        if (imem_req_o) imem_rdata_i <= itcm(imem_addr_o);
        else            imem_rdata_i <= 32'hBAD0_BAD0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected fetch stream restarts at a new base after reset or redirect.
    task automatic refill(input logic [31:0] base);
        exp_q.delete();
        for (int i = 0; i < 512; i++) exp_q.push_back(base + 32'(i * 4));
    endtask

    // Scoreboard monitor: pop on each handshake, bound occupancy, count requests, rebase on redirect/reset.
    always @(negedge clk) begin
        logic [31:0] e;
        #3;
        if (!reset) begin
            refill(32'h0);
        end else begin
            chk("q_le_depth", 32'(q_count_o <= 3'd4), 32'd1);
            if (inst_valid_o && inst_ready_i) begin
                chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_pc", inst_pc_o, e);
                    chk("sb_inst", inst_o, itcm(e));
                    hs_cnt++;
                end
            end
            if (imem_req_o) req_seen++;
            if (redirect_i) refill(redirect_pc_i);
        end
    end

    initial begin
        int r0;
        int h0;
        reset         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        inst_ready_i  = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #2;
        chk("rst_req",   32'(imem_req_o),   32'd0);
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_count", 32'(q_count_o),    32'd0);
        chk("rst_inst",  inst_o,            32'd0);
        chk("rst_pc",    inst_pc_o,         32'd0);
        chk("rst_addr",  imem_addr_o,       32'd0);

        // 1: release, addresses 0,4,8 from cycle 1, first valid at cycle 3, then 1/clk
        @(negedge clk); reset = 1'b1; #2;
        chk("t1_wait_req", 32'(imem_req_o), 32'd0);
        @(negedge clk); #2;
        chk("t1_c1_req",   32'(imem_req_o), 32'd1);
        chk("t1_c1_addr",  imem_addr_o,     32'h0);
        chk("t1_c1_valid", 32'(inst_valid_o), 32'd0);
        @(negedge clk); #2;
        chk("t1_c2_addr",  imem_addr_o,     32'h4);
        chk("t1_c2_valid", 32'(inst_valid_o), 32'd0);
        @(negedge clk); #2;
        chk("t1_c3_addr",  imem_addr_o,     32'h8);
        chk("t1_c3_valid", 32'(inst_valid_o), 32'd1);
        chk("t1_c3_pc",    inst_pc_o,       32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #2;
            chk("t1_rate_valid", 32'(inst_valid_o), 32'd1);
            chk("t1_rate_req",   32'(imem_req_o),   32'd1);
        end

        // 6: asynchronous reset mid-burst clears outputs within the cycle
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        chk("t6_valid", 32'(inst_valid_o), 32'd0);
        chk("t6_req",   32'(imem_req_o),   32'd0);
        chk("t6_count", 32'(q_count_o),    32'd0);
        chk("t6_inst",  inst_o,            32'd0);
        chk("t6_pc",    inst_pc_o,         32'd0);
        chk("t6_addr",  imem_addr_o,       32'd0);

        // 2: restart with ready held low: exactly QDEPTH requests, then drain in order
        inst_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk); reset = 1'b1; r0 = req_seen;
        repeat (10) @(negedge clk);
        #2;
        chk("t2_req_total", 32'(req_seen - r0), 32'd4);
        chk("t2_count",     32'(q_count_o),     32'd4);
        chk("t2_req_held",  32'(imem_req_o),    32'd0);
        chk("t2_head_pc",   inst_pc_o,          32'h0);
        chk("t2_head_inst", inst_o,             itcm(32'h0));
        @(negedge clk); inst_ready_i = 1'b1;
        repeat (12) @(negedge clk);

        // 3: redirect with 3 queued and a response in flight
        reset = 1'b0; inst_ready_i = 1'b0;
        @(negedge clk); reset = 1'b1;
        repeat (5) @(negedge clk);
        redirect_i = 1'b1; redirect_pc_i = 32'h100;
        #2;
        chk("t3_pre_count", 32'(q_count_o), 32'd3);
        chk("t3_r_req",     32'(imem_req_o), 32'd0);
        @(negedge clk); redirect_i = 1'b0; inst_ready_i = 1'b1; #2;
        chk("t3_r1_count", 32'(q_count_o),    32'd0);
        chk("t3_r1_req",   32'(imem_req_o),   32'd1);
        chk("t3_r1_addr",  imem_addr_o,       32'h100);
        chk("t3_r1_valid", 32'(inst_valid_o), 32'd0);
        @(negedge clk); #2;
        chk("t3_r2_addr",  imem_addr_o,       32'h104);
        chk("t3_r2_valid", 32'(inst_valid_o), 32'd0);
        @(negedge clk); #2;
        chk("t3_r3_valid", 32'(inst_valid_o), 32'd1);
        chk("t3_r3_pc",    inst_pc_o,         32'h100);
        chk("t3_r3_inst",  inst_o,            itcm(32'h100));

        // 4: PC wrap past the top of the address space
        @(negedge clk); redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC; #2;
        chk("t4_r_req", 32'(imem_req_o), 32'd0);
        @(negedge clk); redirect_i = 1'b0; #2;
        chk("t4_addr0", imem_addr_o, 32'hFFFF_FFFC);
        @(negedge clk); #2;
        chk("t4_addr1", imem_addr_o, 32'h0);
        @(negedge clk); #2;
        chk("t4_pc0", inst_pc_o, 32'hFFFF_FFFC);
        @(negedge clk); #2;
        chk("t4_valid1", 32'(inst_valid_o), 32'd1);
        chk("t4_pc1",    inst_pc_o,         32'h0);

        // Redirect during the idle cycle after reset only moves the start PC
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h200; #2;
        chk("tw_req", 32'(imem_req_o), 32'd0);
        @(negedge clk); redirect_i = 1'b0; #2;
        chk("tw_req1",  32'(imem_req_o), 32'd1);
        chk("tw_addr1", imem_addr_o,     32'h200);

        // 5: random ready and redirects against the scoreboard
        h0 = hs_cnt;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            inst_ready_i  = 1'($urandom_range(0, 1));
            redirect_i    = ($urandom_range(0, 15) == 0);
            redirect_pc_i = $urandom & 32'hFFFF_FFFC;
        end
        @(negedge clk); redirect_i = 1'b0; inst_ready_i = 1'b1;
        repeat (8) @(negedge clk);
        #2;
        chk("t5_progress", 32'((hs_cnt - h0) > 2000), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
